// File: rtl/far_mem_responder.sv
// Far-memory responder: backs the cache FM port with a line array,
// answering fills after a fixed latency and a minimum spacing between responses.
module far_mem_responder #(
  parameter int ADRS_WIDTH = 8,
  parameter int CL_WIDTH = 64,
  parameter int TQ_WIDTH = 4,
  parameter int OP_WIDTH = 2,
  parameter logic [OP_WIDTH-1:0] FILL_REQ_OP = 2'b01,
  parameter logic [OP_WIDTH-1:0] DIRTY_EVICT_OP = 2'b10,
  parameter int RD_LATENCY = 11,
  parameter int RSP_GAP = 1,
  parameter int FIFO_DEPTH = 8,
  localparam int REQ_WIDTH =
    1 + OP_WIDTH + ADRS_WIDTH + CL_WIDTH + TQ_WIDTH,
  localparam int RSP_WIDTH = 1 + CL_WIDTH + TQ_WIDTH,
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQ_WIDTH-1:0] cache2fm_req_q3,
  output logic [RSP_WIDTH-1:0] fm2cache_rd_rsp,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                 overflow,
  output logic                 illegal_op
);

  localparam int DATA_LSB = TQ_WIDTH;
  localparam int ADR_LSB = DATA_LSB + CL_WIDTH;
  localparam int OP_LSB = ADR_LSB + ADRS_WIDTH;
  localparam int VLD_BIT = OP_LSB + OP_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LINES = 2 ** ADRS_WIDTH;

  localparam logic [7:0] DUE_OFS = 8'(RD_LATENCY - 1);
  localparam logic [3:0] GAP_LD = 4'(RSP_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT =
    CNT_WIDTH'(FIFO_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP = 2'd2;

  logic                  req_valid;
  logic [OP_WIDTH-1:0]   req_op;
  logic [ADRS_WIDTH-1:0] req_idx;
  logic [CL_WIDTH-1:0]   req_data;
  logic [TQ_WIDTH-1:0]   req_tq;

  assign req_valid = cache2fm_req_q3[VLD_BIT];
  assign req_op = cache2fm_req_q3[OP_LSB +: OP_WIDTH];
  assign req_idx = cache2fm_req_q3[ADR_LSB +: ADRS_WIDTH];
  assign req_data = cache2fm_req_q3[DATA_LSB +: CL_WIDTH];
  assign req_tq = cache2fm_req_q3[0 +: TQ_WIDTH];

  logic is_fill;
  logic is_evict;
  logic is_bad;

  always_comb begin
    is_fill = 1'b0;
    is_evict = 1'b0;
    is_bad = 1'b0;
    if (req_valid) begin
      unique case (1'b1)
        (req_op == FILL_REQ_OP): is_fill = 1'b1;
        (req_op == DIRTY_EVICT_OP): is_evict = 1'b1;
        default: is_bad = 1'b1;
      endcase
    end
  end

  // Line array is deliberately not reset so it can be preloaded.
  logic [CL_WIDTH-1:0] mem [LINES];
  logic [CL_WIDTH-1:0] rd_data;

  assign rd_data = mem[req_idx];

  always_ff @(posedge clk) begin
    if (!rst && is_evict) begin
      mem[req_idx] <= req_data;
    end
  end

  logic [PTR_W:0]        wptr;
  logic [PTR_W:0]        rptr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  empty;
  logic                  full;
  logic [TQ_WIDTH-1:0]   fifo_tq [FIFO_DEPTH];
  logic [CL_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [7:0]            fifo_due [FIFO_DEPTH];

  assign count = wptr - rptr;
  assign empty = (count == '0);
  assign full = (count == FULL_CNT);
  assign outstanding = count;

  logic [7:0]          cyc;
  logic [7:0]          age;
  logic                eligible;
  logic [3:0]          gap_cnt;
  logic [3:0]          gap_nxt;
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                launch;
  logic                push;
  logic                drop;

  // Due is stored one cycle early because the response is registered.
  assign age = cyc - fifo_due[rptr[PTR_W-1:0]];
  assign eligible = !empty && !age[7];
  assign launch = eligible && (gap_cnt == 4'd0);
  assign push = is_fill && (!full || launch);
  assign drop = is_fill && full && !launch;

  always_comb begin
    gap_nxt = gap_cnt;
    state_nxt = IDLE;
    if (launch) begin
      gap_nxt = GAP_LD;
      state_nxt = SEND;
    end else begin
      if (gap_cnt != 4'd0) begin
        gap_nxt = gap_cnt - 4'd1;
      end
      state_nxt = (gap_nxt != 4'd0) ? GAP : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_tq[wptr[PTR_W-1:0]] <= req_tq;
      fifo_data[wptr[PTR_W-1:0]] <= rd_data;
      fifo_due[wptr[PTR_W-1:0]] <= cyc + DUE_OFS;
    end
  end

  logic [CL_WIDTH-1:0] rsp_data;
  logic [TQ_WIDTH-1:0] rsp_tq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gap_cnt <= 4'd0;
      cyc <= 8'd0;
      wptr <= '0;
      rptr <= '0;
      rsp_data <= '0;
      rsp_tq <= '0;
      overflow <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      cyc <= cyc + 8'd1;
      state <= state_nxt;
      gap_cnt <= gap_nxt;
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (launch) begin
        rptr <= rptr + 1'b1;
        rsp_data <= fifo_data[rptr[PTR_W-1:0]];
        rsp_tq <= fifo_tq[rptr[PTR_W-1:0]];
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (is_bad) begin
        illegal_op <= 1'b1;
      end
    end
  end

  assign fm2cache_rd_rsp = {(state == SEND), rsp_data, rsp_tq};

endmodule

// File: tb/tb_far_mem_responder.sv
// Bench for far_mem_responder: table of requests plus timing sequences,
// responses checked against a scoreboard of expected cycle, tag and data.
module tb_far_mem_responder;

  localparam int LAT = 11;
  localparam int GAPC = 4;
  localparam int DEPTH = 8;
  localparam logic [1:0] OP_FILL = 2'b01;
  localparam logic [1:0] OP_EVICT = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic [7:0]  req_idx = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_tq = '0;
  logic [78:0] req;
  logic [68:0] rsp;
  logic [3:0]  outstanding;
  logic        overflow;
  logic        illegal_op;

  assign req = {req_valid, req_op, req_idx, req_data, req_tq};

  far_mem_responder #(
    .RD_LATENCY(LAT),
    .RSP_GAP(GAPC),
    .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .cache2fm_req_q3(req),
    .fm2cache_rd_rsp(rsp),
    .outstanding(outstanding),
    .overflow(overflow),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  tq;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  idx;
    logic [63:0] data;
    logic [3:0]  tq;
    logic [63:0] exp_data;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[10];
  int          last_exp = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_ovf = 1'b0;
  logic        m_ill = 1'b0;
  logic [63:0] last_data = '0;
  logic [3:0]  last_tq = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, tcyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rsp[68]) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_cycle", 64'(tcyc), 64'(e.cyc));
          chk("rsp_tq", 64'(rsp[3:0]), 64'(e.tq));
          chk("rsp_data", rsp[67:4], e.data);
          last_data = e.data;
          last_tq = e.tq;
        end
      end else begin
        chk("hold_data", rsp[67:4], last_data);
        chk("hold_tq", 64'(rsp[3:0]), 64'(last_tq));
      end
    end
  end

  task automatic step(input logic v, input logic [1:0] op,
                      input logic [7:0] idx, input logic [63:0] d,
                      input logic [3:0] tq, input logic [63:0] expd);
    int occ;
    int occ2;
    int e;
    @(negedge clk);
    occ = 0;
    occ2 = 0;
    foreach (sbq[i]) begin
      if (sbq[i].cyc > tcyc) occ++;
      if (sbq[i].cyc > tcyc + 1) occ2++;
    end
    chk("outstanding", 64'(outstanding), 64'(occ));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("illegal_op", 64'(illegal_op), 64'(m_ill));
    req_valid = v;
    req_op = op;
    req_idx = idx;
    req_data = d;
    req_tq = tq;
    if (v) begin
      if (op == OP_FILL) begin
        if (occ2 >= DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          e = (tcyc + LAT > last_exp + GAPC) ?
              tcyc + LAT : last_exp + GAPC;
          sbq.push_back('{e, tq, expd});
          last_exp = e;
        end
      end else if (op != OP_EVICT) begin
        m_ill = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 8'h0, 64'h0, 4'h0, 64'h0);
  endtask

  task automatic fill(input logic [7:0] idx, input logic [3:0] tq,
                      input logic [63:0] expd);
    step(1'b1, OP_FILL, idx, 64'h0, tq, expd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    sbq.delete();
    last_exp = 0;
    m_ovf = 1'b0;
    m_ill = 1'b0;
    last_data = '0;
    last_tq = '0;
    chk("rst_valid", 64'(rsp[68]), 64'd0);
    chk("rst_data", rsp[67:4], 64'd0);
    chk("rst_tq", 64'(rsp[3:0]), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_illegal", 64'(illegal_op), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{OP_EVICT, 8'h40, 64'hDEAD, 4'd0, 64'h0};
    tbl[1] = '{OP_FILL, 8'h40, 64'h0, 4'd1, 64'hDEAD};
    tbl[2] = '{OP_EVICT, 8'h41, 64'h1111_2222_3333_4444, 4'd0, 64'h0};
    tbl[3] = '{OP_EVICT, 8'h40, 64'hBEEF, 4'd0, 64'h0};
    tbl[4] = '{OP_FILL, 8'h41, 64'h0, 4'd2, 64'h1111_2222_3333_4444};
    tbl[5] = '{OP_FILL, 8'h40, 64'h0, 4'd3, 64'hBEEF};
    tbl[6] = '{OP_EVICT, 8'h40, 64'hCAFE, 4'd0, 64'h0};
    tbl[7] = '{OP_FILL, 8'h40, 64'h0, 4'd4, 64'hCAFE};
    tbl[8] = '{OP_BAD, 8'h41, 64'h0, 4'd0, 64'h0};
    tbl[9] = '{OP_FILL, 8'h41, 64'h0, 4'd5, 64'h1111_2222_3333_4444};

    do_reset();
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].op, tbl[i].idx, tbl[i].data, tbl[i].tq,
           tbl[i].exp_data);
    end
    idle(40);

    for (int i = 0; i < 4; i++) fill(8'h40, 4'(i), 64'hCAFE);
    idle(40);

    do_reset();
    u_dut.mem[8'h12] = 64'hABBA_BABA_0000_1123;
    idle(2);
    fill(8'h12, 4'd3, 64'hABBA_BABA_0000_1123);
    idle(20);

    for (int i = 0; i < 9; i++) fill(8'h12, 4'(i), 64'hABBA_BABA_0000_1123);
    idle(60);

    step(1'b1, OP_EVICT, 8'h55, 64'h5555_AAAA, 4'd0, 64'h0);
    fill(8'h55, 4'd7, 64'h5555_AAAA);
    fill(8'h12, 4'd8, 64'hABBA_BABA_0000_1123);
    idle(2);
    do_reset();
    idle(30);
    fill(8'h55, 4'd6, 64'h5555_AAAA);
    idle(20);

    do_reset();
    idle(249);
    fill(8'h41, 4'd9, 64'h1111_2222_3333_4444);
    idle(20);
    step(1'b1, 2'b00, 8'h41, 64'h0, 4'd0, 64'h0);
    idle(3);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
